eth_rx: RTL and testbench
=========================

Name: eth_rx

Overview:
Receive-side Ethernet pipe, the counterpart of the UDP transmit path. It takes the PHY-side beat stream, which carries MAC preamble, addresses, optional VLAN tag, ethertype, IPv4 and UDP headers, UDP payload, padding and FCS. It strips and checks the headers and streams only the UDP payload to the application with per-beat byte lengths. After the frame's term beat it reports the FCS check result. It sits between the PCS receive interface and the application receive logic, and reuses the shared crc block.

Parameters:
DATA_W, 16, beat width; KEEP_W = DATA_W/8; LEN_W = $clog2(KEEP_W+1); HEAD_N must be a multiple of KEEP_W.
BLOCK_N, 8, PHY block bytes; BLOCK_LEN_W = $clog2(BLOCK_N+1).
VLAN_TAG, 1, frame carries an 802.1Q tag (TPID 16'h8100 checked, VID ignored).
MAC_PRE_N, 8, preamble+SFD bytes, excluded from CRC.
MAC_DST_ADDR, {24'h0,24'hFCD4F2}, own MAC address; frame destination must match.
IP_DST_ADDR, {8'd206,8'd200,8'd127,8'd128}, own IPv4 address; must match.
DST_PORT, 16'd18170, accepted UDP destination port.
PKT_LEN_W, 16, UDP length width.
CRC_RESIDUE, 32'hC704DD7B, crc_o value after a good frame including FCS, in the same bit order crc_o is produced.
HEAD_N, 8+12+(VLAN_TAG?4:0)+2+20+8 (54), total header bytes.

Ports:
clk  in  1  clock
nreset  in  1  reset, synchronous, active-low
phy_valid_i  in  1  beat present this cycle
phy_ctrl_v_i  in  1  beat carries control (start/term)
phy_start_i  in  1  first beat of frame (preamble byte 0 in lane 0)
phy_term_i  in  1  final beat of frame
phy_term_len_i  in  BLOCK_LEN_W  valid bytes in term beat (0..KEEP_W), lanes from 0
phy_data_i  in  DATA_W  frame bytes, byte n of beat in [8n+:8], earliest byte in lane 0
app_valid_o  out  1  payload beat valid
app_data_o  out  DATA_W  payload bytes, lane 0 first
app_len_o  out  LEN_W  valid payload bytes in beat, 1..KEEP_W
app_last_o  out  1  final payload beat
app_cancel_o  out  1  1-cycle pulse: already-delivered payload must be discarded
app_crc_v_o  out  1  1-cycle pulse: FCS verdict for the delivered packet
app_crc_ok_o  out  1  FCS good, qualified by app_crc_v_o

Behaviour:
- Reset: FSM=IDLE, counters 0, every output 0. Reset mid-frame drops the frame silently, with no cancel pulse.
- All app_* outputs are registered: payload accepted on a phy_valid_i beat at cycle T appears at T+1.
- States:
  - IDLE: phy_valid_i & phy_start_i goes to HEAD, byte count = KEEP_W.
  - HEAD: each valid beat is stored into head_q at byte offset count, and count += KEEP_W. When count reaches HEAD_N the FSM goes to CHK.
  - CHK: the first post-header beat. Header match is evaluated combinationally from head_q. On match it forwards the beat as DATA; on mismatch it goes to DROP.
  - DATA: forwards payload. Moves to FOOT when remaining ≤ KEEP_W on a beat.
  - FOOT: consumes padding and FCS until term.
  - DROP: waits for term with no app output.
  - Term in FOOT or DROP returns to IDLE.
- Header match requires all of: destination MAC == MAC_DST_ADDR; TPID == 8100 if VLAN_TAG; ethertype 0800; IP byte0 == 45; IP protocol == 17; IP destination == IP_DST_ADDR; UDP destination port == DST_PORT; UDP length ≥ 8. Multi-byte fields are big-endian in byte order.
- Payload: remaining = UDP length − 8, loaded in CHK. Each beat outputs app_len_o = min(KEEP_W, remaining) and app_last_o = (remaining ≤ KEEP_W), then remaining −= KEEP_W. Bytes in lanes ≥ app_len_o are don't-care.
- Payload of 0 bytes: CHK goes straight to FOOT and no app beat is produced; the crc pulse is still issued.
- CRC:
  - crc start_i is driven on the beat at byte offset MAC_PRE_N.
  - valid_i covers every beat from that offset through the term beat.
  - len_i = KEEP_W, or phy_term_len_i on the term beat; lanes ≥ len are masked to 0.
  - With the term beat at cycle T, app_crc_v_o pulses at T+2 with app_crc_ok_o = (crc_o == CRC_RESIDUE). This happens only for frames that passed header match.
- Early term:
  - Term in HEAD or CHK returns to IDLE with no output.
  - Term in DATA before app_last_o was issued returns to IDLE and pulses app_cancel_o at T+1; no crc pulse.
- phy_start_i in any non-IDLE state aborts the current frame. The new frame is restarted in HEAD. If the aborted frame was in DATA or FOOT, app_cancel_o pulses.
- phy_valid_i=0 freezes all state. Beats with phy_ctrl_v_i & ~start & ~term are ignored.

Test Plan:
- Good frame, 20-byte payload, 78 bytes after preamble+header+FCS, 39 beats → 10 app beats of len 2, last on the 10th, app_cancel_o never asserted. app_crc_v_o=1 with app_crc_ok_o=1 two cycles after term.
- Same frame with one FCS bit flipped → identical payload beats, then app_crc_v_o=1 with app_crc_ok_o=0.
- Destination MAC byte changed to 0x00 → no app_valid_o and no crc pulse; FSM back in IDLE after term. Repeat the check separately for a wrong ethertype, IP protocol 6, and destination port 80.
- 1-byte payload 0xA5 with 13 pad bytes → one app beat, len 1, last=1, data[7:0]=A5. Padding is not forwarded and crc_ok=1.
- Term with term_len 0 after 4 payload beats of a 20-byte payload → app_cancel_o pulse 1 cycle after term; no crc pulse.
- phy_start_i during DATA → app_cancel_o pulse and the new frame is received correctly. Separately, nreset low mid-DATA → all outputs 0 next cycle, and the next frame is received correctly.

Source files
------------

// File: rtl/eth_rx.sv
// eth_rx: strips preamble/MAC/VLAN/IPv4/UDP headers, streams UDP payload with per-beat lengths
// and reports the FCS verdict two cycles after the frame's term beat.
module eth_rx #(
    parameter int          DATA_W       = 16,
    parameter int          BLOCK_N      = 8,
    parameter bit          VLAN_TAG     = 1'b1,
    parameter int          MAC_PRE_N    = 8,
    parameter logic [47:0] MAC_DST_ADDR = {24'h0, 24'hFCD4F2},
    parameter logic [31:0] IP_DST_ADDR  = {8'd206, 8'd200, 8'd127, 8'd128},
    parameter logic [15:0] DST_PORT     = 16'd18170,
    parameter int          PKT_LEN_W    = 16,
    parameter logic [31:0] CRC_RESIDUE  = 32'hC704DD7B,
    parameter int          KEEP_W       = DATA_W / 8,
    parameter int          LEN_W        = $clog2(KEEP_W + 1),
    parameter int          BLOCK_LEN_W  = $clog2(BLOCK_N + 1),
    parameter int          HEAD_N       = MAC_PRE_N + 12 + (VLAN_TAG ? 4 : 0) + 2 + 20 + 8
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   phy_valid_i,
    input  logic                   phy_ctrl_v_i,
    input  logic                   phy_start_i,
    input  logic                   phy_term_i,
    input  logic [BLOCK_LEN_W-1:0] phy_term_len_i,
    input  logic [DATA_W-1:0]      phy_data_i,
    output logic                   app_valid_o,
    output logic [DATA_W-1:0]      app_data_o,
    output logic [LEN_W-1:0]       app_len_o,
    output logic                   app_last_o,
    output logic                   app_cancel_o,
    output logic                   app_crc_v_o,
    output logic                   app_crc_ok_o
);
    localparam int ETH_O = MAC_PRE_N + 12 + (VLAN_TAG ? 4 : 0);
    localparam int IP_O  = ETH_O + 2;
    localparam int UDP_O = IP_O + 20;
    localparam int CNT_W = $clog2(HEAD_N + 1);

    typedef enum logic [2:0] {IDLE, HEAD, CHK, DATA, FOOT, DROP} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PKT_LEN_W-1:0]   rem_q, rem_d;
    logic [7:0]             head_q [HEAD_N];
    logic [7:0]             head_d [HEAD_N];
    logic [31:0]            crc_q, crc_d, crc_o;
    logic                   valid_q, valid_d, last_q, last_d, cancel_q, cancel_d;
    logic                   pend_q, pend_d, crc_v_q, crc_v_d, crc_ok_q, crc_ok_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic                   beat, start, term, match, fwd, store, crc_en, crc_start;
    logic [PKT_LEN_W-1:0]   udp_len, cur_rem;
    logic [CNT_W-1:0]       off;
    logic [BLOCK_LEN_W-1:0] crc_len;

    // Reflected CRC-32 over the first n lanes of a beat; crc_o is this register bit-reversed.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [DATA_W-1:0] d,
                                             input logic [BLOCK_LEN_W-1:0] n);
        logic [31:0] s;
        s = c;
        for (int b = 0; b < KEEP_W; b++)
            for (int i = 0; i < 8; i++)
                if (BLOCK_LEN_W'(b) < n)
                    s = (s >> 1) ^ ((s[0] ^ d[8*b+i]) ? 32'hEDB88320 : 32'h0);
        return s;
    endfunction

    assign crc_o = {<<{crc_q}};

    // Control beats that are neither start nor term carry no frame data.
    assign beat  = phy_valid_i & ~(phy_ctrl_v_i & ~phy_start_i & ~phy_term_i);
    assign start = beat & phy_start_i;
    assign term  = beat & phy_term_i;

    assign udp_len = {head_q[UDP_O+4], head_q[UDP_O+5]};
    assign match   = {head_q[MAC_PRE_N], head_q[MAC_PRE_N+1], head_q[MAC_PRE_N+2],
                      head_q[MAC_PRE_N+3], head_q[MAC_PRE_N+4], head_q[MAC_PRE_N+5]} == MAC_DST_ADDR
                   && (!VLAN_TAG || {head_q[MAC_PRE_N+12], head_q[MAC_PRE_N+13]} == 16'h8100)
                   && {head_q[ETH_O], head_q[ETH_O+1]} == 16'h0800
                   && head_q[IP_O] == 8'h45 && head_q[IP_O+9] == 8'd17
                   && {head_q[IP_O+16], head_q[IP_O+17], head_q[IP_O+18], head_q[IP_O+19]} == IP_DST_ADDR
                   && {head_q[UDP_O+2], head_q[UDP_O+3]} == DST_PORT
                   && udp_len >= PKT_LEN_W'(8);
    assign cur_rem = state_q == CHK ? udp_len - PKT_LEN_W'(8) : rem_q;

    assign store     = start | (beat & state_q == HEAD & ~term);
    assign off       = start ? '0 : count_q;
    assign crc_start = state_q == HEAD && count_q == CNT_W'(MAC_PRE_N);
    assign crc_en    = beat & ~start & (state_q == HEAD ? count_q >= CNT_W'(MAC_PRE_N) : state_q != IDLE);
    assign crc_len   = term ? phy_term_len_i : BLOCK_LEN_W'(KEEP_W);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            crc_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            len_q    <= '0;
            last_q   <= 1'b0;
            cancel_q <= 1'b0;
            pend_q   <= 1'b0;
            crc_v_q  <= 1'b0;
            crc_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            crc_q    <= crc_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            len_q    <= len_d;
            last_q   <= last_d;
            cancel_q <= cancel_d;
            pend_q   <= pend_d;
            crc_v_q  <= crc_v_d;
            crc_ok_q <= crc_ok_d;
        end
    end

    always_ff @(posedge clk) head_q <= head_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        head_d  = head_q;
        crc_d   = crc_en ? crc_step(crc_start ? '1 : crc_q, phy_data_i, crc_len) : crc_q;
        if (store)
            for (int b = 0; b < KEEP_W; b++)
                head_d[off + CNT_W'(b)] = phy_data_i[8*b+:8];
        if (start) begin
            state_d = HEAD;
            count_d = CNT_W'(KEEP_W);
        end else if (beat) begin
            case (state_q)
                HEAD: begin
                    count_d = count_q + CNT_W'(KEEP_W);
                    state_d = term ? IDLE : count_d == CNT_W'(HEAD_N) ? CHK : HEAD;
                end
                CHK, DATA: begin
                    rem_d   = cur_rem - PKT_LEN_W'(KEEP_W);
                    state_d = term ? IDLE : (state_q == CHK && !match) ? DROP
                            : cur_rem > PKT_LEN_W'(KEEP_W) ? DATA : FOOT;
                end
                FOOT, DROP: state_d = term ? IDLE : state_q;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        fwd      = beat & ~start & ~term & (state_q == DATA | (state_q == CHK & match & cur_rem != '0));
        valid_d  = fwd;
        data_d   = fwd ? phy_data_i : '0;
        len_d    = !fwd ? '0 : cur_rem < PKT_LEN_W'(KEEP_W) ? cur_rem[LEN_W-1:0] : LEN_W'(KEEP_W);
        last_d   = fwd & (cur_rem <= PKT_LEN_W'(KEEP_W));
        cancel_d = (start & (state_q == DATA | state_q == FOOT)) | (term & ~start & state_q == DATA);
        pend_d   = term & ~start & state_q == FOOT;
        crc_v_d  = pend_q;
        crc_ok_d = pend_q & (crc_o == CRC_RESIDUE);
    end

    assign app_valid_o  = valid_q;
    assign app_data_o   = data_q;
    assign app_len_o    = len_q;
    assign app_last_o   = last_q;
    assign app_cancel_o = cancel_q;
    assign app_crc_v_o  = crc_v_q;
    assign app_crc_ok_o = crc_ok_q;
endmodule

// File: tb/tb_eth_rx.sv
// tb_eth_rx: builds complete Ethernet/IPv4/UDP frames with a real FCS and checks the
// payload stream, cancel pulses and CRC verdicts against what the frame contents imply.
module tb_eth_rx;
    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        phy_valid_i = 1'b0, phy_ctrl_v_i = 1'b0, phy_start_i = 1'b0, phy_term_i = 1'b0;
    logic [3:0]  phy_term_len_i = '0;
    logic [15:0] phy_data_i = '0;
    logic        app_valid_o, app_last_o, app_cancel_o, app_crc_v_o, app_crc_ok_o;
    logic [15:0] app_data_o;
    logic [1:0]  app_len_o;

    eth_rx dut (
        .clk(clk), .nreset(nreset),
        .phy_valid_i(phy_valid_i), .phy_ctrl_v_i(phy_ctrl_v_i), .phy_start_i(phy_start_i),
        .phy_term_i(phy_term_i), .phy_term_len_i(phy_term_len_i), .phy_data_i(phy_data_i),
        .app_valid_o(app_valid_o), .app_data_o(app_data_o), .app_len_o(app_len_o),
        .app_last_o(app_last_o), .app_cancel_o(app_cancel_o),
        .app_crc_v_o(app_crc_v_o), .app_crc_ok_o(app_crc_ok_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] d; int len; logic last; } beat_t;

    int         checks = 0, failures = 0, cyc = 0, term_cyc = 0, start_cyc = 0;
    logic [7:0] frm[$];
    logic [7:0] pay[$];
    beat_t      rx[$];
    int         canc[$];
    int         crcc[$];
    logic       crco[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (app_valid_o) rx.push_back('{d: app_data_o, len: int'(app_len_o), last: app_last_o});
        if (app_cancel_o) canc.push_back(cyc);
        if (app_crc_v_o) begin
            crcc.push_back(cyc);
            crco.push_back(app_crc_ok_o);
        end
    end

    // Standard Ethernet CRC-32, computed MSB-first on bit-reflected input.
    function automatic logic [31:0] fcs();
        logic [31:0] c = '1;
        logic [31:0] r;
        for (int k = 8; k < frm.size(); k++)
            for (int i = 0; i < 8; i++) begin
                logic fb;
                fb = c[31] ^ frm[k][i];
                c = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
            end
        for (int i = 0; i < 32; i++) r[i] = c[31-i];
        return ~r;
    endfunction

    // bad: 0 none, 1 dst MAC, 2 ethertype, 3 IP protocol, 4 UDP dst port
    task automatic build(input int plen, input int bad, input bit flip, input logic [7:0] b0);
        logic [31:0] c;
        logic [15:0] ul, tl;
        ul = 16'(plen + 8);
        tl = 16'(plen + 28);
        frm.delete();
        pay.delete();
        frm = {8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
               8'h00, 8'h00, 8'h00, 8'hFC, 8'hD4, bad == 1 ? 8'h00 : 8'hF2,
               8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h81, 8'h00, 8'h00, 8'h05,
               8'h08, bad == 2 ? 8'hDD : 8'h00,
               8'h45, 8'h00, tl[15:8], tl[7:0], 8'h00, 8'h01, 8'h40, 8'h00, 8'h40,
               bad == 3 ? 8'h06 : 8'h11, 8'h00, 8'h00,
               8'hC0, 8'hA8, 8'h01, 8'h02, 8'hCE, 8'hC8, 8'h7F, 8'h80,
               8'h04, 8'hD2, bad == 4 ? 8'h00 : 8'h46, bad == 4 ? 8'h50 : 8'hFA,
               ul[15:8], ul[7:0], 8'h00, 8'h00};
        for (int k = 0; k < plen; k++) pay.push_back(k == 0 ? b0 : 8'($urandom));
        frm = {frm, pay};
        for (int k = plen; k < 14; k++) frm.push_back(8'h00);
        c = fcs();
        frm = {frm, c[7:0], c[15:8], c[23:16], c[31:24]};
        if (flip) begin
            int p;
            p = frm.size() - 1 - int'($urandom_range(0, 3));
            frm[p] = frm[p] ^ 8'(1 << $urandom_range(0, 7));
        end
    endtask

    task automatic idle();
        phy_valid_i = 0; phy_ctrl_v_i = 0; phy_start_i = 0; phy_term_i = 0; phy_term_len_i = '0;
    endtask

    task automatic clear();
        rx.delete(); canc.delete(); crcc.delete(); crco.delete();
    endtask

    task automatic settle(input int n);
        idle();
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends frm[from..to) two bytes per beat, with random stalls and ignored control beats.
    task automatic send(input int from, input int to, input bit with_term);
        for (int i = from; i < to; i += 2) begin
            if ($urandom_range(0, 7) == 0) begin
                idle();
                @(posedge clk); #1;
            end
            if (i != from && $urandom_range(0, 9) == 0) begin
                phy_valid_i = 1; phy_ctrl_v_i = 1; phy_start_i = 0; phy_term_i = 0;
                phy_data_i = 16'($urandom);
                @(posedge clk); #1;
            end
            phy_valid_i    = 1;
            phy_start_i    = (i == 0);
            phy_term_i     = with_term && (i + 2 >= to);
            phy_ctrl_v_i   = phy_start_i | phy_term_i;
            phy_term_len_i = (to - i >= 2) ? 4'd2 : 4'd1;
            phy_data_i     = {(i + 1 < frm.size()) ? frm[i+1] : 8'($urandom), frm[i]};
            @(posedge clk); #1;
            if (phy_start_i) start_cyc = cyc;
            if (phy_term_i) term_cyc = cyc;
            idle();
        end
    endtask

    // Number of received beats (from index off) that disagree with chunking pay into 2-byte beats.
    function automatic int rx_diff(input int off);
        int e = 0;
        for (int k = 0; off + k < rx.size(); k++) begin
            int n, l;
            n = pay.size() - 2 * k;
            l = n < 2 ? n : 2;
            if (n <= 0) e++;
            else if (rx[off+k].len != l || rx[off+k].last !== (n <= 2) || rx[off+k].d[7:0] !== pay[2*k]
                     || (l == 2 && rx[off+k].d[15:8] !== pay[2*k+1])) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        nreset = 0;
        for (int k = 0; k < 3; k++) begin
            phy_valid_i = 1'($urandom); phy_start_i = 1'($urandom); phy_term_i = 1'($urandom);
            phy_data_i = 16'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({app_valid_o, app_data_o, app_len_o, app_last_o, app_cancel_o, app_crc_v_o, app_crc_ok_o} !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d got v=%0b d=%h l=%0d last=%0b c=%0b cv=%0b ok=%0b want all 0",
                         k, app_valid_o, app_data_o, app_len_o, app_last_o, app_cancel_o, app_crc_v_o, app_crc_ok_o);
            end
        end
        idle();
        nreset = 1;
        settle(2);
    endtask

    task automatic test_good_frame(input bit flip);
        build(20, 0, flip, 8'($urandom));
        clear();
        send(0, frm.size(), 1);
        settle(4);
        checks++;
        if (rx.size() !== 10) begin failures++; $display("FAIL frame%0b_beats got=%0d want=10", flip, rx.size()); end
        checks++;
        if (rx_diff(0) !== 0) begin failures++; $display("FAIL frame%0b_payload bad_beats=%0d want=0", flip, rx_diff(0)); end
        checks++;
        if (canc.size() !== 0) begin failures++; $display("FAIL frame%0b_cancel got=%0d pulses want=0", flip, canc.size()); end
        checks++;
        if (crcc.size() !== 1 || crcc[0] !== term_cyc + 1 || crco[0] !== !flip) begin
            failures++;
            $display("FAIL frame%0b_crc pulses=%0d at=%0d ok=%0b want 1 pulse at %0d ok=%0b", flip, crcc.size(),
                     crcc.size() > 0 ? crcc[0] : -1, crco.size() > 0 ? crco[0] : 1'bx, term_cyc + 1, !flip);
        end
    endtask

    task automatic test_header_mismatch();
        for (int b = 1; b <= 4; b++) begin
            build(20, b, 0, 8'($urandom));
            clear();
            send(0, frm.size(), 1);
            settle(4);
            checks++;
            if (rx.size() !== 0) begin failures++; $display("FAIL mismatch%0d_beats got=%0d want=0", b, rx.size()); end
            checks++;
            if (crcc.size() + canc.size() !== 0) begin
                failures++;
                $display("FAIL mismatch%0d_pulses crc=%0d cancel=%0d want 0 0", b, crcc.size(), canc.size());
            end
        end
        build(6, 0, 0, 8'($urandom));
        clear();
        send(0, frm.size(), 1);
        settle(4);
        checks++;
        if (rx.size() !== 3 || rx_diff(0) !== 0) begin
            failures++;
            $display("FAIL mismatch_recovery beats=%0d bad=%0d want 3 0", rx.size(), rx_diff(0));
        end
        checks++;
        if (crcc.size() !== 1 || crco[0] !== 1'b1) begin
            failures++;
            $display("FAIL mismatch_recovery_crc pulses=%0d want 1 ok", crcc.size());
        end
    endtask

    task automatic test_one_byte();
        build(1, 0, 0, 8'hA5);
        clear();
        send(0, frm.size(), 1);
        settle(4);
        checks++;
        if (rx.size() !== 1) begin failures++; $display("FAIL one_byte_beats got=%0d want=1", rx.size()); end
        checks++;
        if (rx.size() > 0 && (rx[0].len !== 1 || rx[0].last !== 1'b1 || rx[0].d[7:0] !== 8'hA5)) begin
            failures++;
            $display("FAIL one_byte_beat len=%0d last=%0b d=%h want 1 1 A5", rx[0].len, rx[0].last, rx[0].d[7:0]);
        end
        checks++;
        if (crcc.size() !== 1 || crcc[0] !== term_cyc + 1 || crco[0] !== 1'b1) begin
            failures++;
            $display("FAIL one_byte_crc pulses=%0d want 1 ok at %0d", crcc.size(), term_cyc + 1);
        end
    endtask

    task automatic test_early_term();
        build(20, 0, 0, 8'($urandom));
        clear();
        send(0, 62, 0);
        phy_valid_i = 1; phy_ctrl_v_i = 1; phy_term_i = 1; phy_term_len_i = 4'd0; phy_data_i = 16'($urandom);
        @(posedge clk); #1;
        term_cyc = cyc;
        settle(4);
        checks++;
        if (rx.size() !== 4 || rx_diff(0) !== 0) begin
            failures++;
            $display("FAIL early_term_beats got=%0d bad=%0d want 4 0", rx.size(), rx_diff(0));
        end
        checks++;
        if (canc.size() !== 1 || canc[0] !== term_cyc) begin
            failures++;
            $display("FAIL early_term_cancel pulses=%0d at=%0d want 1 at %0d", canc.size(),
                     canc.size() > 0 ? canc[0] : -1, term_cyc);
        end
        checks++;
        if (crcc.size() !== 0) begin failures++; $display("FAIL early_term_crc got=%0d pulses want=0", crcc.size()); end
    endtask

    task automatic test_back_to_back();
        build(20, 0, 0, 8'($urandom));
        clear();
        send(0, 62, 0);
        build(12, 0, 0, 8'($urandom));
        send(0, frm.size(), 1);
        settle(4);
        checks++;
        if (rx.size() !== 10) begin failures++; $display("FAIL restart_beats got=%0d want=10", rx.size()); end
        checks++;
        if (rx_diff(4) !== 0) begin failures++; $display("FAIL restart_payload bad_beats=%0d want=0", rx_diff(4)); end
        checks++;
        if (canc.size() !== 1 || canc[0] !== start_cyc) begin
            failures++;
            $display("FAIL restart_cancel pulses=%0d at=%0d want 1 at %0d", canc.size(),
                     canc.size() > 0 ? canc[0] : -1, start_cyc);
        end
        checks++;
        if (crcc.size() !== 1 || crcc[0] !== term_cyc + 1 || crco[0] !== 1'b1) begin
            failures++;
            $display("FAIL restart_crc pulses=%0d want 1 ok at %0d", crcc.size(), term_cyc + 1);
        end
    endtask

    task automatic test_reset_mid();
        build(20, 0, 0, 8'($urandom));
        clear();
        send(0, 60, 0);
        nreset = 0;
        @(posedge clk); #1;
        checks++;
        if ({app_valid_o, app_data_o, app_len_o, app_last_o, app_cancel_o, app_crc_v_o, app_crc_ok_o} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got v=%0b d=%h l=%0d c=%0b want all 0", app_valid_o, app_data_o,
                     app_len_o, app_cancel_o);
        end
        nreset = 1;
        @(posedge clk); #1;
        checks++;
        if (canc.size() !== 0) begin failures++; $display("FAIL reset_mid_cancel got=%0d want=0", canc.size()); end
        build(20, 0, 0, 8'($urandom));
        clear();
        send(0, frm.size(), 1);
        settle(4);
        checks++;
        if (rx.size() !== 10 || rx_diff(0) !== 0) begin
            failures++;
            $display("FAIL reset_mid_next beats=%0d bad=%0d want 10 0", rx.size(), rx_diff(0));
        end
        checks++;
        if (crcc.size() !== 1 || crco[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_next_crc pulses=%0d want 1 ok", crcc.size());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int plen, bad, n;
            bit flip;
            plen = int'($urandom_range(0, 30));
            bad  = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 4)) : 0;
            flip = 1'($urandom);
            n    = bad == 0 ? (plen + 1) / 2 : 0;
            build(plen, bad, flip, 8'($urandom));
            clear();
            send(0, frm.size(), 1);
            settle(4);
            checks++;
            if (rx.size() !== n || rx_diff(0) !== 0) begin
                failures++;
                $display("FAIL random%0d_payload plen=%0d bad=%0d beats=%0d errs=%0d want %0d 0",
                         it, plen, bad, rx.size(), rx_diff(0), n);
            end
            checks++;
            if (canc.size() !== 0) begin failures++; $display("FAIL random%0d_cancel got=%0d want=0", it, canc.size()); end
            checks++;
            if (crcc.size() !== (bad == 0 ? 1 : 0)) begin
                failures++;
                $display("FAIL random%0d_crc_count got=%0d want=%0d", it, crcc.size(), bad == 0 ? 1 : 0);
            end
            else if (bad == 0) begin
                checks++;
                if (crcc[0] !== term_cyc + 1 || crco[0] !== !flip) begin
                    failures++;
                    $display("FAIL random%0d_crc at=%0d ok=%0b want at %0d ok=%0b", it, crcc[0], crco[0],
                             term_cyc + 1, !flip);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame(0);
        test_good_frame(1);
        test_header_mismatch();
        test_one_byte();
        test_early_term();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
